des_key_search_ctrl: RTL
========================

# des_key_search_ctrl

Parametrised multi-lane key-search controller for the DES cracker. It sweeps a programmable 56-bit key-count range across `LANES` pipelined DES engines, one candidate key per lane per cycle. It compares each engine's returned ciphertext against the target and reports the first matching count and its expanded 64-bit key. It is the successor to the single-lane search loop in `top`, adding a programmable start/end range, abort, exhaustion reporting and an N-lane issue path.

## Interface
Parameters:
- `LANES`, 4: parallel engine lanes, 1..16.
- `CNT_W`, 56: key-count width.
- `LAT`, 16: engine latency in cycles from key issue to ciphertext return, ≥1.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `Start`, in, 1: begin search, one-cycle pulse.
- `Stop`, in, 1: abort search.
- `start_count`, in, CNT_W: first count to test, inclusive.
- `end_count`, in, CNT_W: last count to test, inclusive.
- `ciphertext`, in, 64: target ciphertext.
- `eng_key`, out, LANES*56: candidate key for lane i in bits [56i+55:56i].
- `eng_valid`, out, LANES: per-lane issue strobe.
- `eng_ct`, in, LANES*64: engine result, aligned exactly LAT cycles after the issue.
- `count`, out, CNT_W: progress while busy; the matching count once found.
- `Key`, out, 64: expanded matching key.
- `Found`, out, 1: match found, sticky.
- `Done`, out, 1: range exhausted with no match, sticky.
- `Busy`, out, 1: search in progress.

## Operation
- States:
  - IDLE: reset state, and the state entered on Stop.
  - RUN: issuing keys.
  - DRAIN: waiting for in-flight results.
  - FOUND: match reported.
  - EXH: range exhausted with no match.
- Start is honoured only in IDLE, FOUND or EXH. It is ignored while in RUN or DRAIN. On Start: `base` loads `start_count`, Found and Done clear, and the state goes to RUN.
- RUN, each cycle:
  - Lane i issues `base+i`.
  - `eng_valid[i]` is asserted only when `base+i` ≤ `end_count`.
  - `base` increments by LANES.
  - When `base+LANES-1` ≥ `end_count`, the state goes to DRAIN after that issue.
- `base` is held at CNT_W+1 bits, so `end_count` = 2^56-1 causes no wrap-around.
- `end_count` < `start_count`: RUN issues nothing and moves straight to DRAIN. The state reaches EXH after LAT cycles.
- Result path:
  - A LAT-deep shift register carries per-lane valid bits and counts.
  - Lane i matches when the delayed valid is set and `eng_ct[i]` equals `ciphertext`.
- Priority:
  - The earliest issue cycle wins.
  - Within one cycle, the lowest lane index wins.
  - On a match, `count` and `Key` latch, Found sets, the state goes to FOUND, issue stops, and later in-flight matches are discarded.
- DRAIN: when the last in-flight valid retires with no match, Done sets and the state goes to EXH.
- Stop in RUN or DRAIN: the state goes to IDLE, all `eng_valid` drop next cycle, the pipeline flushes, and Found and Done stay 0. Stop in other states has no effect.
- Start and Stop asserted in the same cycle: Stop wins.
- `count` output:
  - RUN/DRAIN: current `base` (low CNT_W bits).
  - FOUND: the matched count.
  - IDLE and EXH: hold.

## Timing
- Reset values: state IDLE; `count`, `Key`, `eng_key` all 0; `eng_valid`, Found, Done and Busy all 0; pipeline valid bits cleared.
- Start is sampled at clock edge T0. First issue (`eng_valid` high) is in cycle T0+1. Busy is high from T0+1.
- An issue in cycle t returns on `eng_ct` in cycle t+LAT. Found and Done assert in cycle t+LAT+1. Busy falls in that same cycle.
- Throughput: LANES keys per cycle with no bubbles.
- Reset asserted mid-search: immediate return to the reset values, with no handshake.

## Configuration
- `KEY_PARITY_EN` defined: `Key` byte j = {count[7j+6:7j], odd parity of those 7 bits}. Matches the standard DES key format.
- `KEY_PARITY_EN` undefined: the parity bit of each byte is 0.
- `eng_key` is always the raw 56-bit count, independent of the macro.

## Test plan
The bench uses a behavioural engine model with LANES=4, LAT=3 and `eng_ct` = {8'h00, key}, delayed 3 cycles.
- Range 0..100, target 64'h25: Found=1 and `count`=37 at T0+14 (issue cycle T0+10, lane 1). Done stays 0.
- Range 0..9, target 64'hFF: issues in T0+1..T0+3, with `eng_valid`=4'b0011 in T0+3. Done=1 at T0+7. Found=0.
- Model modified so lanes 1 and 3 both match in the same cycle, range 0..7: lane-1 count is reported.
- `start_count`=50, `end_count`=10: `eng_valid` is never high. Done=1 at T0+5.
- Stop asserted at T0+4 while a match is in flight: no Found, state IDLE, `eng_valid` low from T0+5. Separately, reset pulsed low mid-RUN: all outputs 0 immediately.
- Target count 0: with `KEY_PARITY_EN`, `Key`=64'h0101010101010101. Without it, `Key`=64'h0.

Source files
------------

// File: rtl/des_key_search_ctrl.sv
// Multi-lane DES key-search controller: sweeps [start_count, end_count] across LANES engines.
// Optional macro KEY_PARITY_EN fills the DES odd-parity bit of every Key byte.
module des_key_search_ctrl #(
  parameter int LANES = 4,
  parameter int CNT_W = 56,
  parameter int LAT   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic                Stop,
  input  logic [CNT_W-1:0]    start_count,
  input  logic [CNT_W-1:0]    end_count,
  input  logic [63:0]         ciphertext,
  output logic [LANES*56-1:0] eng_key,
  output logic [LANES-1:0]    eng_valid,
  input  logic [LANES*64-1:0] eng_ct,
  output logic [CNT_W-1:0]    count,
  output logic [63:0]         Key,
  output logic                Found,
  output logic                Done,
  output logic                Busy
);

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FOUND, EXH} state_t;
  // One spare bit so a range ending at the top count never wraps.
  typedef logic [CNT_W:0] base_t;

  localparam logic [LAT-1:0] TOP_LIVE = LAT'(1) << (LAT - 1);

  state_t           state;
  base_t            base;
  logic [LANES-1:0] pipe_valid [LAT];
  logic [LAT-1:0]   pipe_live;
  logic [CNT_W-1:0] pipe_base  [LAT];

  logic             hit;
  logic [CNT_W-1:0] hit_count;
  logic             active;
  logic             last_issue;
  logic             drain_done;
  base_t            next_base;

  function automatic logic [LANES-1:0] lane_valid(input base_t b, input logic [CNT_W-1:0] last);
    lane_valid = '0;
    for (int i = 0; i < LANES; i++)
      lane_valid[i] = (b + base_t'(i)) <= {1'b0, last};
  endfunction

  function automatic logic [LANES*56-1:0] lane_keys(input base_t b);
    lane_keys = '0;
    for (int i = 0; i < LANES; i++)
      lane_keys[56*i +: 56] = 56'(b + base_t'(i));
  endfunction

  function automatic logic [63:0] expand_key(input logic [CNT_W-1:0] c);
    logic [55:0] raw;
    logic        par;
    raw        = 56'(c);
    expand_key = '0;
    for (int j = 0; j < 8; j++) begin
`ifdef KEY_PARITY_EN
      par = ~^raw[7*j +: 7];
`else
      par = 1'b0;
`endif
      expand_key[8*j +: 8] = {raw[7*j +: 7], par};
    end
  endfunction

  // NOTE: every variable gets a default at the top of an always_comb so no path infers a latch.
  always_comb begin
    hit       = 1'b0;
    hit_count = '0;
    // Walk lanes downward so the lowest matching lane is the one left standing.
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pipe_valid[LAT-1][i] && (eng_ct[64*i +: 64] == ciphertext)) begin
        hit       = 1'b1;
        hit_count = pipe_base[LAT-1] + CNT_W'(i);
      end
    end
  end

  assign active     = (state == RUN) || (state == DRAIN);
  assign next_base  = base + base_t'(LANES);
  assign last_issue = (base + base_t'(LANES - 1)) >= {1'b0, end_count};
  // The final issue cycle sits alone in the last stage once everything younger has retired.
  assign drain_done = (pipe_live == TOP_LIVE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      Key       <= '0;
      eng_key   <= '0;
      eng_valid <= '0;
      Found     <= 1'b0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      pipe_live <= '0;
      for (int k = 0; k < LAT; k++) pipe_valid[k] <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_live[k]  <= pipe_live[k-1];
      end
      pipe_valid[0] <= eng_valid;
      pipe_live[0]  <= (state == RUN);

      if (active && (Stop || hit)) begin
        eng_valid <= '0;
        Busy      <= 1'b0;
        pipe_live <= '0;
        for (int k = 0; k < LAT; k++) pipe_valid[k] <= '0;
        if (Stop) begin
          state <= IDLE;
        end else begin
          state <= FOUND;
          count <= hit_count;
          Key   <= expand_key(hit_count);
          Found <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (last_issue) begin
              state     <= DRAIN;
              eng_valid <= '0;
            end else begin
              base      <= next_base;
              count     <= next_base[CNT_W-1:0];
              eng_key   <= lane_keys(next_base);
              eng_valid <= lane_valid(next_base, end_count);
            end
          end
          DRAIN: begin
            if (drain_done) begin
              state <= EXH;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end
          end
          default: begin
            if (Start && !Stop) begin
              state     <= RUN;
              base      <= {1'b0, start_count};
              count     <= start_count;
              eng_key   <= lane_keys({1'b0, start_count});
              eng_valid <= lane_valid({1'b0, start_count}, end_count);
              Found     <= 1'b0;
              Done      <= 1'b0;
              Busy      <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // NOTE: the count pipeline is pure datapath qualified by pipe_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    pipe_base[0] <= base[CNT_W-1:0];
    for (int k = 1; k < LAT; k++) pipe_base[k] <= pipe_base[k-1];
  end

endmodule
